// File: rtl/order_content_pkg.sv
// Shared constants and FSM encoding for the order-content read engine.
package order_content_pkg;
  localparam int ENTRY_WIDTH     = 976;
  localparam int ADDR_WIDTH      = 12;
  localparam int BEATS_PER_ENTRY = 4;
  localparam logic [31:0] LAST_BEAT_TKEEP = 32'h03FF_FFFF;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_SEND} state_t;
endpackage

// File: rtl/order_content_beat_mux.sv
// Beat selection for one captured entry: data slice, tkeep, tlast and first-beat tuser.
module order_content_beat_mux import order_content_pkg::*; #(
  parameter int DW = 256,
  parameter int UW = 128
) (
  input  logic                   i_vld,
  input  logic [ENTRY_WIDTH-1:0] i_entry,
  input  logic [1:0]             i_beat,
  input  logic [UW-1:0]          i_tuser,
  output logic [DW-1:0]          o_tdata,
  output logic [DW/8-1:0]        o_tkeep,
  output logic                   o_tlast,
  output logic [UW-1:0]          o_tuser
);
  localparam int PAD_W = BEATS_PER_ENTRY*DW - ENTRY_WIDTH;

  logic [BEATS_PER_ENTRY*DW-1:0] w_pad;
  logic                          w_last;

  // Zero-extend so the short final beat carries zeros above the entry.
  assign w_pad  = {{PAD_W{1'b0}}, i_entry};
  assign w_last = (i_beat == 2'(BEATS_PER_ENTRY-1));

  assign o_tdata = i_vld ? w_pad[int'(i_beat)*DW +: DW] : '0;
  assign o_tkeep = !i_vld ? '0 : (w_last ? LAST_BEAT_TKEEP : '1);
  assign o_tlast = i_vld && w_last;
  assign o_tuser = (i_vld && i_beat == 2'd0) ? i_tuser : '0;
endmodule

// File: rtl/order_content_reader.sv
// Arbitrated read of one order-content RAM entry, streamed as a 4-beat AXI4-Stream packet.
// Optional counters stat_served/stat_stall exist when ORDER_READER_STATS_EN is defined.
module order_content_reader import order_content_pkg::*; #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128
) (
  input  logic                            axis_aclk,
  input  logic                            axis_resetn,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [ADDR_WIDTH-1:0]           req_addr,
  input  logic [C_M_AXIS_TUSER_WIDTH-1:0] req_tuser,
  output logic                            ram_rd_req,
  input  logic                            ram_rd_gnt,
  output logic [ADDR_WIDTH-1:0]           ram_addr,
  input  logic [ENTRY_WIDTH-1:0]          ram_dout,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast
`ifdef ORDER_READER_STATS_EN
  ,
  output logic [31:0]                     stat_served,
  output logic [31:0]                     stat_stall
`endif
);
  state_t                          r_state, w_next;
  logic [ADDR_WIDTH-1:0]           r_addr;
  logic [C_M_AXIS_TUSER_WIDTH-1:0] r_tuser;
  logic [ENTRY_WIDTH-1:0]          r_entry;
  logic [1:0]                      r_beat;
  logic                            w_last;
  logic                            w_hs;

  assign w_last = (r_beat == 2'(BEATS_PER_ENTRY-1));
  assign w_hs   = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_tuser <= '0;
      r_entry <= '0;
      r_beat  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_addr  <= req_addr;
          r_tuser <= req_tuser;
        end
        // RAM data is only trusted in the cycle after the granted address.
        S_WAIT: begin
          r_entry <= ram_dout;
          r_beat  <= '0;
        end
        S_SEND: if (m_axis_tready) r_beat <= r_beat + 2'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_next = S_REQ;
      S_REQ:   if (ram_rd_gnt) w_next = S_WAIT;
      S_WAIT:  w_next = S_SEND;
      S_SEND:  if (m_axis_tready && w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Ready is masked by reset so it reads 0 for the whole reset pulse.
  assign req_ready     = (r_state == S_IDLE) && axis_resetn;
  assign ram_rd_req    = (r_state == S_REQ);
  assign ram_addr      = r_addr;
  assign m_axis_tvalid = (r_state == S_SEND);

  order_content_beat_mux #(
    .DW (C_M_AXIS_DATA_WIDTH),
    .UW (C_M_AXIS_TUSER_WIDTH)
  ) u_mux (
    .i_vld   (m_axis_tvalid),
    .i_entry (r_entry),
    .i_beat  (r_beat),
    .i_tuser (r_tuser),
    .o_tdata (m_axis_tdata),
    .o_tkeep (m_axis_tkeep),
    .o_tlast (m_axis_tlast),
    .o_tuser (m_axis_tuser)
  );

`ifdef ORDER_READER_STATS_EN
  logic [31:0] r_stat_served, r_stat_stall;

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_stat_served <= '0;
      r_stat_stall  <= '0;
    end else begin
      if (w_hs && w_last) r_stat_served <= r_stat_served + 32'd1;
      if ((m_axis_tvalid && !m_axis_tready) || (ram_rd_req && !ram_rd_gnt))
        r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_served = r_stat_served;
  assign stat_stall  = r_stat_stall;
`else
  logic w_unused;
  assign w_unused = w_hs;
`endif
endmodule
